life_draw: RTL and testbench
============================

Name: life_draw

Overview:
- Consumer end of the life engine's cell-state stream. Takes per-cell results (ready/alive/changed/x/y) and paints each cell as a SCALE×SCALE block of pixels into a framebuffer write port.
- The life engine has no backpressure, so cells are buffered in a small FIFO while the painter issues one pixel write per accepted handshake.
- Sits between life and the framebuffer/bram write side of the display pipeline.

Parameters:
CORDW, 16, signed coordinate width (matches life)
WIDTH, 6, world width in cells
HEIGHT, 6, world height in cells
SCALE, 4, pixels per cell side (power of two not required)
FIFO_DEPTH, 8, cell FIFO entries (power of two)
COLRW, 4, pixel colour width
COLR_ALIVE, 4'hF, colour for live cells
COLR_DEAD, 4'h0, colour for dead cells
ONLY_CHANGED, 1, 1 = draw only cells with changed=1; 0 = draw every cell

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cell_ready  in  1  cell result valid (single-cycle strobe)
cell_alive  in  1  cell alive, qualified by cell_ready
cell_changed  in  1  cell state changed, qualified by cell_ready
cell_x  in  CORDW signed  cell column
cell_y  in  CORDW signed  cell row
gen_done  in  1  generation complete strobe
fb_we  out  1  pixel write request
fb_rdy  in  1  framebuffer accepts write when fb_we && fb_rdy
fb_addr  out  FBA  pixel address, FBA = $clog2(WIDTH*SCALE*HEIGHT*SCALE)
fb_colr  out  COLRW  pixel colour
busy  out  1  FIFO non-empty or painter active
drawn  out  1  all cells of the finished generation painted (one-cycle pulse)
overflow  out  1  sticky: a cell was dropped because the FIFO was full

Behaviour:
- Reset (async assert, sync release): fb_we=0, fb_addr=0, fb_colr=0, busy=0, drawn=0, overflow=0; FIFO emptied; state IDLE; done-pending cleared. Reset mid-draw abandons the rectangle; fb_we drops immediately.
- Push: on cell_ready, push {alive, x, y} when (ONLY_CHANGED==0 || cell_changed) and 0<=x<WIDTH and 0<=y<HEIGHT. Out-of-range cells are silently discarded.
- FIFO full on push: the cell is dropped and overflow is set. overflow stays set until rst.
- Push and pop in the same cycle while full: the pop frees a slot, so the push is accepted with no overflow.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, pop and go to LOAD.
  - LOAD (1 cycle):
    - base = (y*SCALE)*FB_W + x*SCALE, with FB_W = WIDTH*SCALE.
    - fb_colr = alive ? COLR_ALIVE : COLR_DEAD.
    - Pixel counters px=py=0; go to DRAW.
  - DRAW:
    - fb_we=1 and fb_addr = current address.
    - On fb_we && fb_rdy, advance: px++ and addr++; at px==SCALE-1 set px=0, py++, addr += FB_W-SCALE+1.
    - The accepted write with px==py==SCALE-1 ends the rectangle: fb_we=0; go to LOAD if the FIFO is non-empty (pop), else IDLE.
    - While fb_rdy=0, fb_addr, fb_colr and fb_we are held stable.
- Address arithmetic:
  - Incremental only; no multiplier in the DRAW loop.
  - The LOAD multiplies are by constants.
  - Coordinates are truncated to the unsigned index width after the range check.
- Latency:
  - cell_ready at cycle 0, FIFO empty, FSM IDLE: first fb_we in cycle 3.
  - One rectangle takes ≥SCALE² cycles in DRAW plus 1 cycle in LOAD.
- Done handling:
  - gen_done sets done-pending.
  - drawn pulses for 1 cycle when done-pending is set, the FIFO is empty and the state is IDLE; done-pending then clears.
  - gen_done in the same cycle as the final cell_ready: that cell is still painted before drawn.
  - A second gen_done while pending is absorbed.
- busy = FIFO non-empty || state != IDLE, registered.

Decomposition:
- Package life_pkg:
  - cell entry struct {alive, x idx, y idx}
  - painter state enum {IDLE, LOAD, DRAW}
  - FB_W/FB_H/FBA localparam helpers
- Sub-module cell_fifo: synchronous FIFO with full/empty flags, same clk/rst, parameterised width and depth.

Test Plan:
- SCALE=4, ONLY_CHANGED=1, fb_rdy=1; one cell (0,0) alive and changed -> 16 writes, one per cycle, at addresses 0-3, 24-27, 48-51, 72-75, colour F; first fb_we 3 cycles after cell_ready.
- Cell (5,5) dead and changed -> addresses 500..503 through 572..575, colour 0; cell (6,2) or (-1,0) -> no writes.
- ONLY_CHANGED=1, cell with changed=0 -> no writes and no FIFO push; ONLY_CHANGED=0 same stimulus -> 16 writes.
- fb_rdy toggling 1,0,0,1 during DRAW -> fb_addr and fb_colr held on stalled cycles; exactly 16 accepted writes in order.
- fb_rdy=0, 10 back-to-back cells, then fb_rdy=1 -> first cell popped into painter, 8 held in FIFO, 1 dropped, overflow=1; 9 rectangles drawn.
- gen_done with the last cell, then after the final write -> drawn pulses exactly once; rst asserted mid-DRAW -> fb_we=0 asynchronously, busy=0, overflow=0.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and framebuffer geometry helpers for the life cell painter.
package life_pkg;

  localparam int IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAW
  } paint_state_t;

  typedef struct packed {
    logic             alive;
    logic [IDX_W-1:0] x;
    logic [IDX_W-1:0] y;
  } cell_t;

  localparam int CELL_W = $bits(cell_t);

  function automatic int fb_w(input int width, input int scale);
    return width * scale;
  endfunction

  function automatic int fb_h(input int height, input int scale);
    return height * scale;
  endfunction

  function automatic int fba_w(input int width, input int height, input int scale);
    return $clog2(fb_w(width, scale) * fb_h(height, scale));
  endfunction

endpackage

// File: rtl/cell_fifo.sv
// Synchronous FIFO; a push while full is accepted only when a pop frees a slot in the same cycle.
module cell_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/life_draw.sv
// Paints each life cell result as a SCALE x SCALE pixel block through a
// valid/ready framebuffer write port, buffering cells in a small FIFO.
module life_draw
  import life_pkg::*;
#(
  parameter int             CORDW        = 16,
  parameter int             WIDTH        = 6,
  parameter int             HEIGHT       = 6,
  parameter int             SCALE        = 4,
  parameter int             FIFO_DEPTH   = 8,
  parameter int             COLRW        = 4,
  parameter logic [COLRW-1:0] COLR_ALIVE = {COLRW{1'b1}},
  parameter logic [COLRW-1:0] COLR_DEAD  = '0,
  parameter bit             ONLY_CHANGED = 1'b1,
  localparam int            FBA          = fba_w(WIDTH, HEIGHT, SCALE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cell_ready,
  input  logic                    cell_alive,
  input  logic                    cell_changed,
  input  logic signed [CORDW-1:0] cell_x,
  input  logic signed [CORDW-1:0] cell_y,
  input  logic                    gen_done,
  output logic                    fb_we,
  input  logic                    fb_rdy,
  output logic [FBA-1:0]          fb_addr,
  output logic [COLRW-1:0]        fb_colr,
  output logic                    busy,
  output logic                    drawn,
  output logic                    overflow
);

  localparam int PW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int FBW = fb_w(WIDTH, SCALE);
  localparam logic [FBA-1:0] ROW_STEP  = FBA'(SCALE * FBW);
  localparam logic [FBA-1:0] CELL_STEP = FBA'(SCALE);
  localparam logic [FBA-1:0] WRAP_STEP = FBA'(FBW - SCALE + 1);
  localparam logic [PW-1:0]  PMAX      = PW'(SCALE - 1);
  localparam logic signed [CORDW-1:0] X_LIM = CORDW'(WIDTH);
  localparam logic signed [CORDW-1:0] Y_LIM = CORDW'(HEIGHT);

  paint_state_t   state_q;
  cell_t          cur_q;
  logic [PW-1:0]  px_q;
  logic [PW-1:0]  py_q;
  logic           fb_we_q;
  logic [FBA-1:0] fb_addr_q;
  logic [COLRW-1:0] fb_colr_q;
  logic           busy_q;
  logic           drawn_q;
  logic           ovf_q;
  logic           done_pend_q;

  logic           in_range;
  logic           want_push;
  cell_t          push_cell;
  cell_t          fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fire;
  logic           last_px;
  logic           pop;
  logic [FBA-1:0] base;

  // Coordinates are range-checked as signed values, then narrowed to indices.
  assign in_range  = !cell_x[CORDW-1] && (cell_x < X_LIM) &&
                     !cell_y[CORDW-1] && (cell_y < Y_LIM);
  assign want_push = cell_ready && ((ONLY_CHANGED == 1'b0) || cell_changed) && in_range;
  assign push_cell = '{alive: cell_alive, x: cell_x[IDX_W-1:0], y: cell_y[IDX_W-1:0]};

  assign fire    = fb_we_q && fb_rdy;
  assign last_px = (px_q == PMAX) && (py_q == PMAX);
  assign pop     = !fifo_empty &&
                   ((state_q == IDLE) || ((state_q == DRAW) && fire && last_px));
  assign base    = FBA'(cur_q.y) * ROW_STEP + FBA'(cur_q.x) * CELL_STEP;

  cell_fifo #(
    .W     (CELL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (want_push),
    .pop_i   (pop),
    .din_i   (push_cell),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      px_q        <= '0;
      py_q        <= '0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_colr_q   <= '0;
      busy_q      <= 1'b0;
      drawn_q     <= 1'b0;
      ovf_q       <= 1'b0;
      done_pend_q <= 1'b0;
    end else begin
      busy_q  <= !fifo_empty || (state_q != IDLE);
      ovf_q   <= ovf_q | (want_push && fifo_full && !pop);
      drawn_q <= 1'b0;
      // A fresh gen_done defers the pulse by a cycle rather than being lost.
      if (gen_done) begin
        done_pend_q <= 1'b1;
      end else if (done_pend_q && fifo_empty && (state_q == IDLE)) begin
        done_pend_q <= 1'b0;
        drawn_q     <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            cur_q   <= fifo_dout;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          fb_addr_q <= base;
          fb_colr_q <= cur_q.alive ? COLR_ALIVE : COLR_DEAD;
          px_q      <= '0;
          py_q      <= '0;
          fb_we_q   <= 1'b1;
          state_q   <= DRAW;
        end
        DRAW: begin
          if (fire) begin
            if (last_px) begin
              fb_we_q <= 1'b0;
              if (!fifo_empty) begin
                cur_q   <= fifo_dout;
                state_q <= LOAD;
              end else begin
                state_q <= IDLE;
              end
            end else if (px_q == PMAX) begin
              px_q      <= '0;
              py_q      <= py_q + PW'(1);
              fb_addr_q <= fb_addr_q + WRAP_STEP;
            end else begin
              px_q      <= px_q + PW'(1);
              fb_addr_q <= fb_addr_q + FBA'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_colr  = fb_colr_q;
  assign busy     = busy_q;
  assign drawn    = drawn_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_life_draw.sv
// Randomised and directed checks of life_draw against a pixel-level reference model.
module tb_life_draw;

  localparam int CORDW  = 16;
  localparam int WIDTH  = 6;
  localparam int HEIGHT = 6;
  localparam int SCALE  = 4;
  localparam int COLRW  = 4;
  localparam int FBA    = 10;
  localparam int FB_W   = WIDTH * SCALE;
  localparam int CAP    = 9;  // FIFO entries plus the cell held by the painter
  localparam int EW     = FBA + COLRW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                    cell_ready = 1'b0;
  logic                    cell_alive = 1'b0;
  logic                    cell_changed = 1'b0;
  logic signed [CORDW-1:0] cell_x = '0;
  logic signed [CORDW-1:0] cell_y = '0;
  logic                    gen_done = 1'b0;
  logic                    fb_we;
  logic                    fb_rdy = 1'b1;
  logic [FBA-1:0]          fb_addr;
  logic [COLRW-1:0]        fb_colr;
  logic                    busy;
  logic                    drawn;
  logic                    overflow;

  life_draw #(
    .CORDW        (CORDW),
    .WIDTH        (WIDTH),
    .HEIGHT       (HEIGHT),
    .SCALE        (SCALE),
    .FIFO_DEPTH   (8),
    .COLRW        (COLRW),
    .COLR_ALIVE   (4'hF),
    .COLR_DEAD    (4'h0),
    .ONLY_CHANGED (1'b1)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .cell_ready   (cell_ready),
    .cell_alive   (cell_alive),
    .cell_changed (cell_changed),
    .cell_x       (cell_x),
    .cell_y       (cell_y),
    .gen_done     (gen_done),
    .fb_we        (fb_we),
    .fb_rdy       (fb_rdy),
    .fb_addr      (fb_addr),
    .fb_colr      (fb_colr),
    .busy         (busy),
    .drawn        (drawn),
    .overflow     (overflow)
  );

  // scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  int pending   = 0;
  int pix_seen  = 0;
  int drawn_cnt = 0;
  bit exp_ovf   = 1'b0;
  bit done_exp  = 1'b0;
  int rdy_mode  = 0;
  int rdy_cyc   = 0;
  logic [3:0] rdy_pat = 4'b1001;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: one queued pixel per write, in raster order inside each block
  task automatic push_rect(input int x, input int y, input bit alive);
    for (int py = 0; py < SCALE; py++) begin
      for (int px = 0; px < SCALE; px++) begin
        int a;
        logic [COLRW-1:0] c;
        a = (y * SCALE + py) * FB_W + x * SCALE + px;
        c = alive ? 4'hF : 4'h0;
        exp_q.push_back({a[FBA-1:0], c});
      end
    end
  endtask

  task automatic model_cell(input int x, input int y, input bit alive, input bit changed);
    if (changed && x >= 0 && x < WIDTH && y >= 0 && y < HEIGHT) begin
      if (pending >= CAP) begin
        exp_ovf = 1'b1;
      end else begin
        pending++;
        push_rect(x, y, alive);
      end
    end
  endtask

  // fb_rdy driver
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       fb_rdy = rdy_pat[rdy_cyc % 4];
      2:       fb_rdy = 1'($urandom_range(0, 1));
      3:       fb_rdy = 1'b0;
      default: fb_rdy = 1'b1;
    endcase
    rdy_cyc++;
  end

  // monitor: compares every accepted write and every drawn pulse
  always @(negedge clk) begin
    if (!rst) begin
      if (fb_we && !fb_rdy && exp_q.size() > 0) begin
        check("stall_addr", 32'(fb_addr), 32'(exp_q[0][EW-1:COLRW]));
        check("stall_colr", 32'(fb_colr), 32'(exp_q[0][COLRW-1:0]));
      end
      if (fb_we && fb_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(fb_addr), 32'hFFFF_FFFF);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("write_addr", 32'(fb_addr), 32'(e[EW-1:COLRW]));
          check("write_colr", 32'(fb_colr), 32'(e[COLRW-1:0]));
          pix_seen++;
          if (pix_seen % (SCALE * SCALE) == 0) pending--;
        end
      end
      if (drawn) begin
        check("drawn_expected", 32'(drawn), 32'(done_exp));
        check("drawn_after_all_writes", exp_q.size(), 0);
        done_exp = 1'b0;
        drawn_cnt++;
      end
    end
  end

  // driver tasks
  task automatic drive_cell(input int x, input int y, input bit alive, input bit changed,
                            input bit done);
    @(posedge clk); #1;
    cell_ready   = 1'b1;
    cell_alive   = alive;
    cell_changed = changed;
    cell_x       = x[CORDW-1:0];
    cell_y       = y[CORDW-1:0];
    gen_done     = done;
    @(negedge clk); #1;
    model_cell(x, y, alive, changed);
    if (done) done_exp = 1'b1;
  endtask

  task automatic release_in();
    @(posedge clk); #1;
    cell_ready = 1'b0;
    gen_done   = 1'b0;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1;
    gen_done = 1'b1;
    @(negedge clk); #1;
    done_exp = 1'b1;
    @(posedge clk); #1;
    gen_done = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while (!(exp_q.size() == 0 && !busy && !fb_we) && n < max_cycles);
    check("drain_queue", exp_q.size(), 0);
    check("drain_busy", 32'(busy), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int d0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_fb_we", 32'(fb_we), 0);
    check("rst_fb_addr", 32'(fb_addr), 0);
    check("rst_fb_colr", 32'(fb_colr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_drawn", 32'(drawn), 0);
    check("rst_overflow", 32'(overflow), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single live cell at origin, first write latency
    drive_cell(0, 0, 1'b1, 1'b1, 1'b0);
    release_in();
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (fb_we && lat < 0) lat = k;
    end
    check("first_we_latency", lat, 3);
    wait_idle(100);

    // far corner, dead colour
    drive_cell(5, 5, 1'b0, 1'b1, 1'b0);
    release_in();
    wait_idle(100);

    // filtered cells: out of range and unchanged
    drive_cell(6, 2, 1'b1, 1'b1, 1'b0);
    drive_cell(-1, 0, 1'b1, 1'b1, 1'b0);
    drive_cell(0, 6, 1'b1, 1'b1, 1'b0);
    drive_cell(2, 2, 1'b1, 1'b0, 1'b0);
    release_in();
    repeat (4) @(negedge clk);
    check("filtered_busy", 32'(busy), 0);
    check("filtered_fb_we", 32'(fb_we), 0);

    // stalls with fb_rdy pattern 1,0,0,1
    rdy_mode = 1;
    drive_cell(3, 1, 1'b1, 1'b1, 1'b0);
    release_in();
    wait_idle(200);
    rdy_mode = 0;

    // gen_done with the last cell, plus a second absorbed gen_done
    d0 = drawn_cnt;
    drive_cell(1, 4, 1'b1, 1'b1, 1'b1);
    release_in();
    pulse_done();
    wait_idle(100);
    repeat (6) @(negedge clk);
    check("drawn_once", drawn_cnt - d0, 1);
    check("done_cleared", 32'(done_exp), 0);

    // overflow: painter stalled, ten back-to-back cells
    rdy_mode = 3;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      drive_cell(i % WIDTH, i / WIDTH, 1'(i % 2), 1'b1, 1'b0);
    end
    release_in();
    repeat (4) @(negedge clk);
    check("overflow_set", 32'(overflow), 32'(exp_ovf));
    rdy_mode = 0;
    wait_idle(400);
    check("overflow_sticky", 32'(overflow), 32'(exp_ovf));

    // reset in the middle of a rectangle
    drive_cell(2, 3, 1'b1, 1'b1, 1'b0);
    release_in();
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_fb_we", 32'(fb_we), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_overflow", 32'(overflow), 0);
    check("midrst_drawn", 32'(drawn), 0);
    exp_q.delete();
    pending  = 0;
    pix_seen = 0;
    exp_ovf  = 1'b0;
    done_exp = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("postrst_fb_we", 32'(fb_we), 0);

    // randomised cells with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      int x;
      int y;
      int gap;
      x   = int'($urandom_range(0, 7)) - 1;
      y   = int'($urandom_range(0, 7)) - 1;
      gap = int'($urandom_range(0, 12));
      drive_cell(x, y, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b0);
      release_in();
      repeat (gap) @(posedge clk);
    end
    wait_idle(5000);
    check("random_overflow", 32'(overflow), 32'(exp_ovf));
    rdy_mode = 0;

    // final generation marker on an idle painter
    d0 = drawn_cnt;
    pulse_done();
    repeat (4) @(negedge clk);
    check("idle_drawn", drawn_cnt - d0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
